booth_mul_ctrl: RTL and testbench
=================================

# booth_mul_ctrl

Sequencing controller for the iterative signed multiplier: accepts a start request with two operands, runs a radix-4 Booth recode/add/shift loop for WIDTH/2 cycles, and owns the 64-bit result register with its clear and done signalling. It sits between the register-file/ALU issue logic and the multiplier datapath. It replaces the free-running, level-sensitive result capture with a clocked, handshaked start/done protocol.

## Interface
- WIDTH, 32, operand width in bits; must be even and ≥4; result width is 2*WIDTH.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset; one clock domain only.
- op_start  in  1  start request; sampled only in IDLE.
- op_clear  in  1  synchronous abort/clear; highest priority after reset.
- multiplicand  in  WIDTH  signed operand M; captured on accepted start.
- multiplier  in  WIDTH  signed operand Q; captured on accepted start.
- busy  out  1  high in EXEC and DONE states.
- op_done  out  1  one-cycle pulse; result valid.
- result  out  2*WIDTH  signed product; held stable until the next accepted start or clear.

## Operation
- Three states, IDLE → EXEC → DONE → IDLE.
- IDLE: `op_start`=1 and `op_clear`=0 captures the operands.
  - M is stored. Accumulator `acc` (WIDTH+2 bits) is set to 0. Low register `lo` is set to Q. Guard bit `q_m1` is set to 0. Counter `cnt` is set to 0.
  - The state moves to EXEC.
- EXEC, one iteration per cycle:
  - Recode {lo[1:0], q_m1}: 000 and 111 → +0; 001 and 010 → +M; 011 → +2M; 100 → −2M; 101 and 110 → −M.
  - Add the recoded term to `acc`, sign-extended to WIDTH+2 bits, with wrap-around modulo 2^(WIDTH+2).
  - Arithmetic-shift the concatenation {acc, lo, q_m1} right by 2.
  - `cnt` increments. After iteration WIDTH/2 (`cnt` = WIDTH/2−1 at that edge), the state moves to DONE.
- DONE:
  - `result` is loaded with {acc[WIDTH−1:0], lo}.
  - `op_done` is 1 for exactly this cycle.
  - The state moves to IDLE unconditionally.
- `result` is written only on entry to DONE, on clear, or on reset. It is never X; every register has a defined reset value.
- `op_start` in EXEC or DONE is ignored and not queued; operand changes after capture have no effect.
- `op_clear` in any state takes effect at the next edge:
  - state → IDLE; `result`, `acc`, `lo`, `q_m1`, `cnt` → 0; `op_done` → 0.
  - If asserted together with `op_start`, the clear wins and the start is dropped.
- `reset` at any time, including mid-EXEC, immediately forces:
  - state IDLE; all registers 0; `busy`=0, `op_done`=0, `result`=0.

## Timing
- Reset values: `busy`=0, `op_done`=0, `result`=0.
- Start accepted at edge t. EXEC runs for cycles t+1 … t+WIDTH/2.
  - `op_done`=1 and the new `result` are visible after edge t+WIDTH/2+1.
  - Latency is WIDTH/2+1 cycles (17 for WIDTH=32).
- `busy` rises after edge t and falls after edge t+WIDTH/2+2.
- The earliest next accepted start is the edge at which `op_done` is low again (back-to-back every WIDTH/2+2 cycles).
- All outputs are registered; there are no combinational input→output paths.

## Structure
- Package `mul_pkg`:
  - state enum {IDLE, EXEC, DONE};
  - Booth operation enum {B_ZERO, B_PM, B_P2M, B_NM, B_N2M};
  - counter width constant $clog2(WIDTH/2).
- Sub-module `booth_r4_enc`: combinational recoder from 3 bits to the Booth operation, plus term generation (sign-extended ±M/±2M, WIDTH+2 bits).
- Controller FSM, counter, shift registers and result register live in `booth_mul_ctrl`.

## Test plan
- Reset, then start with M=3, Q=5:
  - `op_done` exactly 17 cycles after the start edge;
  - `result`=64'h0000_0000_0000_000F;
  - `busy` high for 18 cycles.
- M=−1, Q=−1 → `result`=64'h0000_0000_0000_0001. Then M=32'h8000_0000, Q=32'h8000_0000 back-to-back → `result`=64'h4000_0000_0000_0000.
- M=32'h7FFF_FFFF, Q=32'h8000_0000 → `result`=64'hC000_0000_8000_0000. Operands are changed to 0 during EXEC; the result is unchanged.
- Second `op_start` pulses during EXEC and DONE:
  - ignored; exactly one `op_done`;
  - `result` matches the first operands.
- Clear and reset behaviour:
  - `op_clear` at EXEC cycle 5 → next cycle IDLE, `result`=0, no `op_done`.
  - `op_clear` and `op_start` together → no start.
  - `reset` asserted mid-EXEC → all outputs 0 asynchronously; after release the next start completes normally.
- Random signed operand pairs (≥1000) checked against a 64-bit reference product, including 0, ±1, min and max corners.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the radix-4 Booth multiplier controller.
package mul_pkg;

    localparam int unsigned MulWidth = 32;

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    typedef enum logic [2:0] {BZero, BPm, BP2m, BNm, BN2m} booth_op_e;

    // Iteration counter must hold WIDTH/2-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction

    localparam int unsigned MulCntW = cnt_width(MulWidth);

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder: maps {q[i+1], q[i], q[i-1]} to 0, +-M or +-2M, sign-extended to WIDTH+2.
module booth_r4_enc import mul_pkg::*; #(
    parameter int unsigned WIDTH = MulWidth
) (
    input  logic [2:0]       bits_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH+1:0] term_o
);

    booth_op_e        op;
    logic [WIDTH+1:0] m1;
    logic [WIDTH+1:0] m2;

    assign m1 = {{2{m_i[WIDTH-1]}}, m_i};
    assign m2 = {m_i[WIDTH-1], m_i, 1'b0};

    always_comb begin
        op = BZero;
        case (bits_i)
            3'b001, 3'b010: op = BPm;
            3'b011:         op = BP2m;
            3'b100:         op = BN2m;
            3'b101, 3'b110: op = BNm;
            default:        op = BZero;
        endcase
    end

    always_comb begin
        term_o = '0;
        unique case (op)
            BPm:     term_o = m1;
            BP2m:    term_o = m2;
            BNm:     term_o = -m1;
            BN2m:    term_o = -m2;
            default: term_o = '0;
        endcase
    end

endmodule

// File: rtl/booth_mul_ctrl.sv
// Start/done sequencer for the iterative radix-4 Booth signed multiplier.
// Owns the operand, accumulator and result registers; all outputs are registered.
module booth_mul_ctrl import mul_pkg::*; #(
    parameter int unsigned WIDTH = MulWidth
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               op_start_i,
    input  logic               op_clear_i,
    input  logic [WIDTH-1:0]   multiplicand_i,
    input  logic [WIDTH-1:0]   multiplier_i,
    output logic               busy_o,
    output logic               op_done_o,
    output logic [2*WIDTH-1:0] result_o
);

    localparam int unsigned    CntW    = cnt_width(WIDTH);
    localparam int unsigned    AccW    = WIDTH + 2;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH / 2 - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   m_q;
    logic [AccW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               qm1_q, qm1_d;
    logic [CntW-1:0]    cnt_q;
    logic [2*WIDTH-1:0] result_q;
    logic               busy_q;
    logic               done_q;
    logic [AccW-1:0]    term;
    logic [AccW-1:0]    sum;

    booth_r4_enc #(
        .WIDTH (WIDTH)
    ) u_enc (
        .bits_i ({lo_q[1:0], qm1_q}),
        .m_i    (m_q),
        .term_o (term)
    );

    // One iteration: add the recoded term, then arithmetic shift {acc, lo, q_m1} right by 2.
    always_comb begin
        sum   = acc_q + term;
        acc_d = {{2{sum[AccW-1]}}, sum[AccW-1:2]};
        lo_d  = {sum[1:0], lo_q[WIDTH-1:2]};
        qm1_d = lo_q[1];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            m_q      <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (op_clear_i) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            lo_q     <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    busy_q <= op_start_i;
                    if (op_start_i) begin
                        m_q     <= multiplicand_i;
                        acc_q   <= '0;
                        lo_q    <= multiplier_i;
                        qm1_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    busy_q <= 1'b1;
                    acc_q  <= acc_d;
                    lo_q   <= lo_d;
                    qm1_q  <= qm1_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    busy_q   <= 1'b1;
                    result_q <= {acc_q[WIDTH-1:0], lo_q};
                    done_q   <= 1'b1;
                    state_q  <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign op_done_o = done_q;
    assign result_o  = result_q;

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Directed and randomized checks of booth_mul_ctrl at WIDTH=32.
module tb_booth_mul_ctrl;

    localparam int unsigned W = 32;

    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic         op_start = 1'b0;
    logic         op_clear = 1'b0;
    logic [W-1:0] mcand    = '0;
    logic [W-1:0] mplier   = '0;
    logic         busy;
    logic         op_done;
    logic [2*W-1:0] result;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    booth_mul_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .op_start_i     (op_start),
        .op_clear_i     (op_clear),
        .multiplicand_i (mcand),
        .multiplier_i   (mplier),
        .busy_o         (busy),
        .op_done_o      (op_done),
        .result_o       (result)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    // Starts one op, zeroes the operand inputs after capture and waits (bounded) for op_done.
    // With noise set, extra start pulses land on an EXEC edge and on the DONE edge.
    task automatic run_op(input logic [31:0] m, input logic [31:0] q, input logic [63:0] exp,
                          input bit noise, input string tag);
        int lat;
        int bcnt;
        bit got;
        @(negedge clk);
        mcand    = m;
        mplier   = q;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        mcand    = '0;
        mplier   = '0;
        lat  = 0;
        bcnt = busy ? 1 : 0;
        got  = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk);
            #1;
            if (busy) bcnt++;
            op_start = noise && (k == 4 || k == 16);
            if (op_done) begin
                got = 1'b1;
                lat = k;
            end
        end
        op_start = 1'b0;
        chk({tag, " latency"}, 64'(lat), 64'd17);
        chk({tag, " result"}, result, exp);
        chk({tag, " busy cycles"}, 64'(bcnt), 64'd18);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk);
            #1;
            if (op_done) n++;
        end
    endtask

    logic [31:0] corners [5];
    int          nd;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        corners = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

        // Reset state
        #1 reset = 1'b1;
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset op_done", 64'(op_done), 64'd0);
        chk("reset result", result, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Basic products, back-to-back
        run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0, "3x5");
        @(posedge clk);
        #1;
        chk("3x5 busy after", 64'(busy), 64'd0);
        chk("3x5 done pulse width", 64'(op_done), 64'd0);
        chk("3x5 result held", result, 64'h0000_0000_0000_000F);

        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, "-1x-1");
        run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, "minxmin");
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 1'b0, "maxxmin");

        // Extra start pulses during EXEC and DONE are dropped
        run_op(32'd1234, 32'hFFFF_FFF9, ref_mul(32'd1234, 32'hFFFF_FFF9), 1'b1, "noise");
        count_dones(20, nd);
        chk("noise extra dones", 64'(nd), 64'd0);
        chk("noise busy idle", 64'(busy), 64'd0);
        chk("noise result kept", result, ref_mul(32'd1234, 32'hFFFF_FFF9));

        // Clear during EXEC
        @(negedge clk);
        mcand    = 32'd3;
        mplier   = 32'd5;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_clear = 1'b0;
        chk("clear busy", 64'(busy), 64'd0);
        chk("clear result", result, 64'd0);
        chk("clear op_done", 64'(op_done), 64'd0);
        count_dones(20, nd);
        chk("clear no done", 64'(nd), 64'd0);

        // Clear together with start: start dropped
        @(negedge clk);
        mcand    = 32'd7;
        mplier   = 32'd9;
        op_start = 1'b1;
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        op_clear = 1'b0;
        chk("clear+start busy", 64'(busy), 64'd0);
        count_dones(20, nd);
        chk("clear+start no done", 64'(nd), 64'd0);
        chk("clear+start result", result, 64'd0);

        // Asynchronous reset mid-EXEC
        run_op(32'd6, 32'd7, 64'd42, 1'b0, "6x7");
        @(negedge clk);
        mcand    = 32'd5;
        mplier   = 32'd7;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        repeat (6) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async reset busy", 64'(busy), 64'd0);
        chk("async reset op_done", 64'(op_done), 64'd0);
        chk("async reset result", result, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0, "post-reset 3x5");

        // Corner pairs, then random operands
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                run_op(corners[i], corners[j], ref_mul(corners[i], corners[j]), 1'b0, "corner");
            end
        end
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom();
            rb = $urandom();
            run_op(ra, rb, ref_mul(ra, rb), 1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
